// File: rtl/video_timing_monitor.sv
// Video timing monitor: recovers line/frame geometry and active-area position from pixel-enable,
// sync and blanking strobes, and tracks timing stability with a SEARCH/MEASURE/LOCKED machine.
module video_timing_monitor #(
  parameter int unsigned HCNT_W      = 10,
  parameter int unsigned VCNT_W      = 9,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              CLK_32M,
  input  logic              RESET,
  input  logic              CE_PIX,
  input  logic              HS,
  input  logic              VS,
  input  logic              HBLK,
  input  logic              VBLK,
  output logic [HCNT_W-1:0] H_TOTAL,
  output logic [HCNT_W-1:0] H_ACTIVE,
  output logic [HCNT_W-1:0] H_SYNC,
  output logic [VCNT_W-1:0] V_TOTAL,
  output logic [VCNT_W-1:0] V_ACTIVE,
  output logic [VCNT_W-1:0] V_SYNC,
  output logic [HCNT_W-1:0] HPOS,
  output logic [VCNT_W-1:0] VPOS,
  output logic              LOCKED,
  output logic              FRAME_DONE,
  output logic              MISMATCH
);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  localparam logic [2:0] LockN = 3'(LOCK_FRAMES);

  function automatic logic [HCNT_W-1:0] f_hinc(input logic [HCNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + HCNT_W'(1) : v;
  endfunction

  function automatic logic [VCNT_W-1:0] f_vinc(input logic [VCNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + VCNT_W'(1) : v;
  endfunction

  logic              r_hs_prev, r_hblk_prev, r_vs_ls, r_vblk_ls;
  logic [HCNT_W-1:0] r_pix_cnt, r_act_cnt, r_syn_cnt, r_hpos;
  logic [VCNT_W-1:0] r_lin_cnt, r_val_cnt, r_vsy_cnt, r_vpos;
  logic [HCNT_W-1:0] r_h_total, r_h_active, r_h_sync;
  logic [VCNT_W-1:0] r_v_total, r_v_active, r_v_sync;
  logic              r_frame_done, r_mismatch;
  logic [2:0]        r_match;
  state_e            r_state;

  logic              w_line_start, w_frame_start, w_sat, w_same;
  logic              w_publish, w_mis;
  logic [2:0]        w_match_nxt, w_match_inc;
  state_e            w_state_nxt;

  assign w_line_start  = CE_PIX && r_hs_prev && !HS;
  // VS is only meaningful at line starts; r_vs_ls holds its value at the previous one.
  assign w_frame_start = w_line_start && !VS && r_vs_ls;
  assign w_sat         = CE_PIX && ((r_pix_cnt == '1) || (r_lin_cnt == '1));
  assign w_match_inc   = r_match + 3'd1;
  assign w_same        = {r_pix_cnt, r_act_cnt, r_syn_cnt, r_lin_cnt, r_val_cnt, r_vsy_cnt} ==
                         {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync};

  // Horizontal measurement; the counts at a line start are the completed line's results.
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      r_hs_prev   <= 1'b1;
      r_hblk_prev <= 1'b1;
      r_pix_cnt   <= '0;
      r_act_cnt   <= '0;
      r_syn_cnt   <= '0;
      r_hpos      <= '0;
    end else if (CE_PIX) begin
      r_hs_prev   <= HS;
      r_hblk_prev <= HBLK;
      if (w_line_start) begin
        r_pix_cnt <= HCNT_W'(1);
        r_act_cnt <= HCNT_W'(!HBLK);
        r_syn_cnt <= HCNT_W'(1);
      end else begin
        r_pix_cnt <= f_hinc(r_pix_cnt, 1'b1);
        r_act_cnt <= f_hinc(r_act_cnt, !HBLK);
        r_syn_cnt <= f_hinc(r_syn_cnt, !HS);
      end
      if (r_hblk_prev && !HBLK) begin
        r_hpos <= '0;
      end else begin
        r_hpos <= f_hinc(r_hpos, !HBLK);
      end
    end
  end

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      r_vs_ls   <= 1'b1;
      r_vblk_ls <= 1'b1;
      r_lin_cnt <= '0;
      r_val_cnt <= '0;
      r_vsy_cnt <= '0;
      r_vpos    <= '0;
    end else if (w_line_start) begin
      r_vs_ls   <= VS;
      r_vblk_ls <= VBLK;
      if (w_frame_start) begin
        r_lin_cnt <= VCNT_W'(1);
        r_val_cnt <= VCNT_W'(!VBLK);
        r_vsy_cnt <= VCNT_W'(1);
      end else begin
        r_lin_cnt <= f_vinc(r_lin_cnt, 1'b1);
        r_val_cnt <= f_vinc(r_val_cnt, !VBLK);
        r_vsy_cnt <= f_vinc(r_vsy_cnt, !VS);
      end
      if (!VBLK) begin
        r_vpos <= r_vblk_ls ? '0 : f_vinc(r_vpos, 1'b1);
      end
    end
  end

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      r_state <= StSearch;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  // Saturation overrides any frame start seen on the same sample.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_publish   = 1'b0;
    w_mis       = 1'b0;
    if (w_sat) begin
      w_state_nxt = StSearch;
      w_match_nxt = '0;
      w_mis       = (r_state == StLocked);
    end else if (w_frame_start) begin
      unique case (r_state)
        StSearch: begin
          w_state_nxt = StMeasure;
          w_match_nxt = '0;
        end
        StMeasure: begin
          w_publish = 1'b1;
          if (w_same) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == LockN) w_state_nxt = StLocked;
          end else begin
            w_match_nxt = '0;
          end
        end
        StLocked: begin
          w_publish = 1'b1;
          if (!w_same) begin
            w_mis       = 1'b1;
            w_match_nxt = '0;
            w_state_nxt = StMeasure;
          end
        end
        default: w_state_nxt = StSearch;
      endcase
    end
  end

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      r_h_total    <= '0;
      r_h_active   <= '0;
      r_h_sync     <= '0;
      r_v_total    <= '0;
      r_v_active   <= '0;
      r_v_sync     <= '0;
      r_frame_done <= 1'b0;
      r_mismatch   <= 1'b0;
    end else begin
      r_frame_done <= w_publish;
      r_mismatch   <= w_mis;
      if (w_publish) begin
        r_h_total  <= r_pix_cnt;
        r_h_active <= r_act_cnt;
        r_h_sync   <= r_syn_cnt;
        r_v_total  <= r_lin_cnt;
        r_v_active <= r_val_cnt;
        r_v_sync   <= r_vsy_cnt;
      end
    end
  end

  always_comb begin
    H_TOTAL    = r_h_total;
    H_ACTIVE   = r_h_active;
    H_SYNC     = r_h_sync;
    V_TOTAL    = r_v_total;
    V_ACTIVE   = r_v_active;
    V_SYNC     = r_v_sync;
    HPOS       = r_hpos;
    VPOS       = r_vpos;
    LOCKED     = (r_state == StLocked);
    FRAME_DONE = r_frame_done;
    MISMATCH   = r_mismatch;
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Bench for video_timing_monitor: a frame table drives scaled-down video modes, expected publishes
// go to a scoreboard queue that a negedge monitor drains on FRAME_DONE/MISMATCH.
module tb_video_timing_monitor;

  logic       clk = 1'b0;
  logic       rst, ce, hs, vs, hblk, vblk;
  logic [9:0] h_total, h_active, h_sync, hpos;
  logic [8:0] v_total, v_active, v_sync, vpos;
  logic       locked, frame_done, mismatch;

  always #5 clk = ~clk;

  video_timing_monitor #(.HCNT_W(10), .VCNT_W(9), .LOCK_FRAMES(2)) dut (
    .CLK_32M(clk), .RESET(rst), .CE_PIX(ce), .HS(hs), .VS(vs), .HBLK(hblk), .VBLK(vblk),
    .H_TOTAL(h_total), .H_ACTIVE(h_active), .H_SYNC(h_sync),
    .V_TOTAL(v_total), .V_ACTIVE(v_active), .V_SYNC(v_sync),
    .HPOS(hpos), .VPOS(vpos), .LOCKED(locked), .FRAME_DONE(frame_done), .MISMATCH(mismatch)
  );

  typedef struct {int l; int hb; int hsw; int n; int vb; int vsw; bit endblk;} geom_t;
  typedef struct {
    geom_t g; int gap; int nd; bit pub; bit mis; bit lk; geom_t pg; bit chk;
  } frame_t;
  typedef struct {bit fd; bit mis; bit lk; int ht; int ha; int hs; int vt; int va; int vs;} exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  frame_t tbl[21];
  geom_t  ga, gae, ga2, gb;
  int     errors = 0;
  int     checks = 0;
  int     pub_n  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input bit fd, input bit mis, input bit lk, input geom_t p);
    exp_t e;
    e.fd = fd; e.mis = mis; e.lk = lk;
    e.ht = p.l; e.ha = p.l - p.hb; e.hs = p.hsw;
    e.vt = p.n; e.va = p.n - p.vb; e.vs = p.vsw;
    return e;
  endfunction

  function automatic frame_t mkf(input geom_t g, input int gap, input int nd, input bit pub,
                                 input bit mis, input bit lk, input geom_t pg, input bit chk);
    frame_t f;
    f.g = g; f.gap = gap; f.nd = (nd == 0) ? g.n : nd;
    f.pub = pub; f.mis = mis; f.lk = lk; f.pg = pg; f.chk = chk;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input frame_t f);
    for (int ln = 0; ln < f.nd; ln++) begin
      for (int p = 0; p < f.g.l; p++) begin
        hs   = (p < f.g.hsw) ? 1'b0 : 1'b1;
        vs   = (ln < f.g.vsw) ? 1'b0 : 1'b1;
        vblk = (ln < f.g.vb);
        hblk = f.g.endblk ? (p >= f.g.l - f.g.hb) : (p < f.g.hb);
        if (ln == 0 && p == 0 && f.pub) sb.push_back(mk_exp(1'b1, f.mis, f.lk, f.pg));
        ce = 1'b1;
        tick();
        // Blanking at line end: HS and HBLK fall together on p == 0.
        if (f.chk && f.g.endblk && ln == 1 && p == 0) check("hpos_coincident_fall", hpos, 0);
        if (f.gap > 0) begin
          ce = 1'b0;
          repeat (f.gap) tick();
        end
      end
    end
    if (f.chk) begin
      check("hpos_max", hpos, f.g.l - f.g.hb - 1);
      check("vpos_max", vpos, f.g.n - f.g.vb - 1);
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_frame(tbl[i]);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_h_total"}, h_total, 0);
    check({pfx, "_h_active"}, h_active, 0);
    check({pfx, "_h_sync"}, h_sync, 0);
    check({pfx, "_v_total"}, v_total, 0);
    check({pfx, "_v_active"}, v_active, 0);
    check({pfx, "_v_sync"}, v_sync, 0);
    check({pfx, "_hpos"}, hpos, 0);
    check({pfx, "_vpos"}, vpos, 0);
    check({pfx, "_locked"}, locked, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
    check({pfx, "_mismatch"}, mismatch, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (frame_done || mismatch)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got frame_done=%0d mismatch=%0d, want no pulse",
                 frame_done, mismatch);
      end else begin
        mon_e = sb.pop_front();
        pub_n++;
        check($sformatf("ev%0d_frame_done", pub_n), frame_done, mon_e.fd);
        check($sformatf("ev%0d_mismatch", pub_n), mismatch, mon_e.mis);
        check($sformatf("ev%0d_locked", pub_n), locked, mon_e.lk);
        check($sformatf("ev%0d_h_total", pub_n), h_total, mon_e.ht);
        check($sformatf("ev%0d_h_active", pub_n), h_active, mon_e.ha);
        check($sformatf("ev%0d_h_sync", pub_n), h_sync, mon_e.hs);
        check($sformatf("ev%0d_v_total", pub_n), v_total, mon_e.vt);
        check($sformatf("ev%0d_v_active", pub_n), v_active, mon_e.va);
        check($sformatf("ev%0d_v_sync", pub_n), v_sync, mon_e.vs);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ce = 1'b0; hs = 1'b1; vs = 1'b1; hblk = 1'b1; vblk = 1'b1;
    ga  = '{64, 16, 5, 20, 4, 2, 1'b0};
    gae = '{64, 16, 5, 20, 4, 2, 1'b1};
    ga2 = '{64, 16, 5, 24, 4, 2, 1'b0};
    gb  = '{80, 20, 6, 22, 5, 3, 1'b0};
    //            geom gap nd pub mis lk  prev chk
    tbl[0]  = mkf(ga,  0, 0, 0, 0, 0, ga,  0);
    tbl[1]  = mkf(ga,  0, 0, 1, 0, 0, ga,  0);
    tbl[2]  = mkf(ga,  0, 0, 1, 0, 0, ga,  0);
    tbl[3]  = mkf(ga,  0, 0, 1, 0, 1, ga,  1);
    tbl[4]  = mkf(gae, 0, 0, 1, 0, 1, ga,  1);
    tbl[5]  = mkf(ga2, 0, 0, 1, 0, 1, gae, 0);
    tbl[6]  = mkf(ga2, 0, 0, 1, 1, 0, ga2, 0);
    tbl[7]  = mkf(ga2, 0, 0, 1, 0, 0, ga2, 0);
    tbl[8]  = mkf(ga2, 0, 0, 1, 0, 1, ga2, 0);
    tbl[9]  = mkf(gb,  3, 0, 1, 0, 1, ga2, 0);
    tbl[10] = mkf(gb,  3, 0, 1, 1, 0, gb,  0);
    tbl[11] = mkf(gb,  3, 0, 1, 0, 0, gb,  0);
    tbl[12] = mkf(gb,  3, 0, 1, 0, 1, gb,  1);
    tbl[13] = mkf(gb,  3, 1, 1, 0, 1, gb,  0);
    tbl[14] = mkf(ga,  0, 0, 0, 0, 0, ga,  0);
    tbl[15] = mkf(ga,  0, 0, 0, 0, 0, ga,  0);
    tbl[16] = mkf(ga,  0, 0, 1, 0, 0, ga,  0);
    tbl[17] = mkf(ga,  0, 0, 1, 0, 0, ga,  0);
    tbl[18] = mkf(ga,  0, 3, 1, 0, 1, ga,  0);
    tbl[19] = mkf(ga,  0, 0, 0, 0, 0, ga,  0);
    tbl[20] = mkf(ga,  0, 1, 1, 0, 0, ga,  0);

    repeat (3) tick();
    check_zero("in_reset");
    rst = 1'b0;
    tick();
    check_zero("after_reset");

    // Lock, coincident HS/HBLK fall, line-count switch, gapped second mode.
    run_range(0, 13);

    // HS stuck high while locked: pix counter saturates, drop to search without a publish.
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, gb));
    hs = 1'b1; vs = 1'b1; hblk = 1'b1; vblk = 1'b1; ce = 1'b1;
    repeat (1100) tick();
    check("sat_locked", locked, 0);
    check("sat_mismatch_seen", sb.size(), 0);

    run_range(14, 18);
    check("pre_reset_locked", locked, 1);
    hs = 1'b1; vs = 1'b1; hblk = 1'b1; vblk = 1'b1; ce = 1'b1;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    tick();
    ce = 1'b0;
    rst = 1'b0;
    tick();
    run_range(19, 20);

    ce = 1'b0;
    repeat (5) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_monitor.md
Name: video_timing_monitor

Overview:
- Receiving end of the video timing interface: consumes the pixel-enable, HS/VS sync and HBLK/VBLK blanking strobes that the video timing generator drives.
- Recovers line/frame geometry from those strobes: totals, active extents, sync widths, plus active-area pixel coordinates.
- Runs a lock state machine that flags stable timing.
- Sits beside the scaler/OSD path and the debug register block; used to validate 15 kHz / 50 Hz / 24 kHz mode switching.

Parameters:
- HCNT_W, 10, width of horizontal measurement counters.
- VCNT_W, 9, width of vertical measurement counters.
- LOCK_FRAMES, 2, consecutive identical frames required to assert LOCKED (range 1..7).

Ports:
- CLK_32M  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- CE_PIX  in  1  pixel enable; all inputs sampled only when high
- HS  in  1  horizontal sync, active low
- VS  in  1  vertical sync, active low
- HBLK  in  1  horizontal blank, active high
- VBLK  in  1  vertical blank, active high
- H_TOTAL  out  HCNT_W  pixels per line
- H_ACTIVE  out  HCNT_W  non-blank pixels per line
- H_SYNC  out  HCNT_W  HS-low pixels per line
- V_TOTAL  out  VCNT_W  lines per frame
- V_ACTIVE  out  VCNT_W  lines with VBLK low at line start
- V_SYNC  out  VCNT_W  lines with VS low at line start
- HPOS  out  HCNT_W  active-area x
- VPOS  out  VCNT_W  active-area y
- LOCKED  out  1  timing stable
- FRAME_DONE  out  1  one-cycle pulse when measurements publish
- MISMATCH  out  1  one-cycle pulse when a locked frame differs

Behaviour:
- Reset (async, active high): every output, counter and edge register is 0; state is SEARCH. Previous HS/VS/HBLK/VBLK samples reset to 1.
- Sampling: all logic advances only on cycles with CE_PIX=1. Events are edges between consecutive CE_PIX samples.
- Line start: HS 1->0.
  - pix_cnt counts CE_PIX samples since the last line start; at line start it loads 1.
  - act_cnt counts samples with HBLK=0; syn_cnt counts samples with HS=0.
  - At line start, the completed line's pix_cnt/act_cnt/syn_cnt are latched as line results; the current sample counts toward the new line.
- Frame start: a line start where VS=0 and VS was 1 at the previous line start. VS is evaluated only at line starts.
  - lin_cnt counts line starts. val_cnt counts line starts with VBLK=0. vsy_cnt counts line starts with VS=0.
- Publish, at each frame start when state is not SEARCH:
  - H_* take the latched line results of the final line of the frame.
  - V_TOTAL, V_ACTIVE, V_SYNC take lin_cnt, val_cnt, vsy_cnt.
  - FRAME_DONE pulses on the cycle after the publishing CE_PIX cycle; outputs are valid on that same cycle.
  - Vertical counters then restart: lin_cnt=1, and val_cnt/vsy_cnt count the current line.
- Saturation: every counter saturates at all-ones. If pix_cnt saturates (no HS edge for 2^HCNT_W-1 samples) or lin_cnt saturates: state -> SEARCH, LOCKED=0. MISMATCH pulses if LOCKED was 1. No publish occurs for that frame.
- State machine:
  - SEARCH -> MEASURE on the first frame start; nothing is published on this transition.
  - MEASURE: at each frame start, compare the new six-value set with the previously published set. Equal: match_cnt+1. Different: match_cnt=0. Always publish. When match_cnt reaches LOCK_FRAMES -> LOCKED, with LOCKED=1 from the FRAME_DONE cycle.
  - LOCKED: at each frame start, publish. Any difference -> MISMATCH pulse (coincident with FRAME_DONE), LOCKED=0, match_cnt=0, state MEASURE.
- HPOS: 0 on HBLK 1->0; +1 per CE_PIX while HBLK=0; holds while HBLK=1.
- VPOS: 0 on the first line start with VBLK=0 after a line start with VBLK=1; +1 on each later line start while VBLK=0; holds otherwise.
- Simultaneous events:
  - Saturation and frame start on the same sample: saturation wins.
  - HS fall and HBLK fall on the same sample: line start is processed first, then HPOS=0.
- Mid-frame RESET: immediate clear. Relocking requires one SEARCH frame plus LOCK_FRAMES+1 publishes.

Test Plan:
1. M72 15 kHz stimulus (line 512 px, HBLK 128, HS 40; frame 284 lines, VBLK 28, VS 6) -> after the 3rd publish H_TOTAL=512, H_ACTIVE=384, H_SYNC=40, V_TOTAL=284, V_ACTIVE=256, V_SYNC=6, LOCKED=1; HPOS reaches 383, VPOS reaches 255.
2. Locked at 284 lines, switch to 50 Hz (312 lines) -> next FRAME_DONE shows V_TOTAL=312 with MISMATCH pulse and LOCKED=0; LOCKED returns after 2 more identical frames.
3. 24 kHz mode (640 px/line, 452 lines) -> H_TOTAL=640, V_TOTAL=452, LOCKED after 3 publishes; CE_PIX gaps of 3 idle cycles do not change any value.
4. HS held high for 1100 samples while LOCKED -> pix_cnt saturates at 1023, MISMATCH pulses, LOCKED=0, state SEARCH, no FRAME_DONE.
5. RESET asserted mid-line while LOCKED -> all outputs 0 asynchronously; after release, first FRAME_DONE comes at the 2nd frame start.
6. HS fall coincident with HBLK fall -> the new line's counts start at 1 and HPOS=0 on that sample; H_ACTIVE unchanged.
